// File: rtl/ecg_sim_pkg.sv
// Shared mode encodings, per-mode range table, reset values and LFSR helper
// for the multi-channel ECG parameter generator.
package ecg_sim_pkg;

  localparam logic [2:0] MODE_NORMAL = 3'd1;
  localparam logic [2:0] MODE_TACHY  = 3'd2;
  localparam logic [2:0] MODE_LOWHRV = 3'd3;
  localparam logic [2:0] MODE_BRADY  = 3'd4;

  localparam logic [10:0] HR_RST  = 11'd76;
  localparam logic [10:0] RR_RST  = 11'd793;
  localparam logic [10:0] HRV_RST = 11'd41;

  // Fibonacci feedback taps for x^16+x^14+x^13+x^11+1 on a left-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {IDLE, SCAN} seq_state_t;

  typedef struct packed {
    logic [10:0] lo;
    logic [10:0] hi;
    logic [10:0] step;
  } range_t;

  typedef struct packed {
    range_t hr;
    range_t rr;
    range_t hrv;
  } mode_rng_t;

  function automatic range_t mk_rng(input logic [10:0] lo, input logic [10:0] hi,
                                    input logic [10:0] step);
    range_t r;
    r.lo   = lo;
    r.hi   = hi;
    r.step = step;
    return r;
  endfunction

  function automatic mode_rng_t mode_lut(input logic [2:0] mode);
    mode_rng_t r;
    mode_rng_t normal;
    normal.hr  = mk_rng(11'd72, 11'd79, 11'd2);
    normal.rr  = mk_rng(11'd760, 11'd820, 11'd10);
    normal.hrv = mk_rng(11'd35, 11'd47, 11'd3);
    case (mode)
      MODE_NORMAL: r = normal;
      MODE_TACHY: begin
        r.hr  = mk_rng(11'd103, 11'd170, 11'd5);
        r.rr  = mk_rng(11'd353, 11'd582, 11'd20);
        r.hrv = mk_rng(11'd70, 11'd110, 11'd8);
      end
      MODE_LOWHRV: begin
        r.hr  = mk_rng(11'd74, 11'd76, 11'd1);
        r.rr  = mk_rng(11'd788, 11'd812, 11'd4);
        r.hrv = mk_rng(11'd8, 11'd11, 11'd1);
      end
      MODE_BRADY: begin
        r.hr  = mk_rng(11'd45, 11'd58, 11'd2);
        r.rr  = mk_rng(11'd1034, 11'd1333, 11'd15);
        r.hrv = mk_rng(11'd30, 11'd60, 11'd4);
      end
      default: r = normal;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ecg_metric_walk.sv
// One metric's pseudo-random target inside [lo..hi] and the slew-limited step
// from the current value toward it; purely combinational.
module ecg_metric_walk
  import ecg_sim_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic [DW-1:0] cur_i,
  input  logic [15:0]   lfsr_i,
  input  range_t        rng_i,
  output logic [DW-1:0] nxt_o,
  output logic          in_rng_o
);

  logic [DW-1:0]  lo_s;
  logic [DW-1:0]  hi_s;
  logic [DW-1:0]  step_s;
  logic [DW-1:0]  span_s;
  logic [DW-1:0]  tgt_s;
  logic [DW+15:0] prod_s;

  // Scale the LFSR into the span, then clamp the move; compares are one bit wider so nothing wraps
  always_comb begin
    lo_s   = DW'(rng_i.lo);
    hi_s   = DW'(rng_i.hi);
    step_s = DW'(rng_i.step);
    span_s = hi_s - lo_s + DW'(1'b1);
    prod_s = (DW+16)'(lfsr_i) * (DW+16)'(span_s);
    tgt_s  = lo_s + DW'(prod_s >> 16);
    if ({1'b0, tgt_s} > ({1'b0, cur_i} + {1'b0, step_s})) begin
      nxt_o = cur_i + step_s;
    end else if (({1'b0, tgt_s} + {1'b0, step_s}) < {1'b0, cur_i}) begin
      nxt_o = cur_i - step_s;
    end else begin
      nxt_o = tgt_s;
    end
    in_rng_o = (nxt_o >= lo_s) && (nxt_o <= hi_s);
  end

endmodule

// File: rtl/ecg_param_gen_mc.sv
// Multi-channel ECG heart-rate / RR / HRV generator: a tick counter starts a
// scan that services one channel per cycle through a shared set of metric walkers.
module ecg_param_gen_mc
  import ecg_sim_pkg::*;
#(
  parameter int          NUM_CH   = 2,
  parameter int          DW       = 12,
  parameter int          TICK_DIV = 50,
  parameter logic [15:0] SEED0    = 16'hACE1,
  parameter logic [15:0] SEED1    = 16'hBEEF,
  parameter logic [15:0] SEED2    = 16'hCAFE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3*NUM_CH-1:0]  mode_i,
  input  logic [NUM_CH-1:0]    freeze_i,
  output logic [DW*NUM_CH-1:0] heart_rate_o,
  output logic [DW*NUM_CH-1:0] rr_interval_o,
  output logic [DW*NUM_CH-1:0] hrv_value_o,
  output logic [NUM_CH-1:0]    upd_valid_o,
  output logic [NUM_CH-1:0]    in_range_o,
  output logic                 tick_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("ecg_param_gen_mc: NUM_CH must be 1..8");
  end
  if (TICK_DIV < NUM_CH + 1) begin : g_bad_tick_div
    $error("ecg_param_gen_mc: TICK_DIV must be at least NUM_CH+1");
  end
  if (DW < 11) begin : g_bad_dw
    $error("ecg_param_gen_mc: DW must be at least 11");
  end
  if (SEED0 == 16'h0000 || SEED1 == 16'h0000 || SEED2 == 16'h0000) begin : g_bad_seed
    $error("ecg_param_gen_mc: LFSR seeds must be nonzero");
  end

  localparam logic [DW-1:0] HR_R  = DW'(HR_RST);
  localparam logic [DW-1:0] RR_R  = DW'(RR_RST);
  localparam logic [DW-1:0] HRV_R = DW'(HRV_RST);

  logic [15:0]           lfsr_hr_q, lfsr_rr_q, lfsr_hrv_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tick_q;
  seq_state_t            state_q;
  logic [IW-1:0]         idx_q;
  logic [DW*NUM_CH-1:0]  hr_q, rr_q, hrv_q;
  logic [NUM_CH-1:0]     upd_q, inrng_q;

  logic [2:0]            ch_mode_s;
  logic                  frz_s;
  mode_rng_t             rng_s;
  logic [DW-1:0]         hr_cur_s, rr_cur_s, hrv_cur_s;
  logic [DW-1:0]         hr_nxt_s, rr_nxt_s, hrv_nxt_s;
  logic                  hr_ok_s, rr_ok_s, hrv_ok_s;

  // Tick counter next state and the operands of the channel currently being serviced
  always_comb begin
    if (cnt_q == CW'(TICK_DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
    end
    ch_mode_s = mode_i[3*int'(idx_q) +: 3];
    frz_s     = freeze_i[idx_q];
    rng_s     = mode_lut(ch_mode_s);
    hr_cur_s  = hr_q[DW*int'(idx_q) +: DW];
    rr_cur_s  = rr_q[DW*int'(idx_q) +: DW];
    hrv_cur_s = hrv_q[DW*int'(idx_q) +: DW];
  end

  ecg_metric_walk #(.DW(DW)) u_walk_hr (
    .cur_i(hr_cur_s), .lfsr_i(lfsr_hr_q), .rng_i(rng_s.hr),
    .nxt_o(hr_nxt_s), .in_rng_o(hr_ok_s)
  );
  ecg_metric_walk #(.DW(DW)) u_walk_rr (
    .cur_i(rr_cur_s), .lfsr_i(lfsr_rr_q), .rng_i(rng_s.rr),
    .nxt_o(rr_nxt_s), .in_rng_o(rr_ok_s)
  );
  ecg_metric_walk #(.DW(DW)) u_walk_hrv (
    .cur_i(hrv_cur_s), .lfsr_i(lfsr_hrv_q), .rng_i(rng_s.hrv),
    .nxt_o(hrv_nxt_s), .in_rng_o(hrv_ok_s)
  );

  // LFSRs, tick counter, scan sequencer and per-channel metric registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_hr_q  <= SEED0;
      lfsr_rr_q  <= SEED1;
      lfsr_hrv_q <= SEED2;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      state_q    <= IDLE;
      idx_q      <= '0;
      hr_q       <= {NUM_CH{HR_R}};
      rr_q       <= {NUM_CH{RR_R}};
      hrv_q      <= {NUM_CH{HRV_R}};
      upd_q      <= '0;
      inrng_q    <= '1;
    end else begin
      lfsr_hr_q  <= lfsr_step(lfsr_hr_q);
      lfsr_rr_q  <= lfsr_step(lfsr_rr_q);
      lfsr_hrv_q <= lfsr_step(lfsr_hrv_q);
      cnt_q      <= cnt_d;
      tick_q     <= (cnt_d == CW'(TICK_DIV - 1));
      upd_q      <= '0;
      case (state_q)
        IDLE: begin
          if (tick_q) begin
            state_q <= SCAN;
            idx_q   <= '0;
          end
        end
        SCAN: begin
          if (!frz_s) begin
            hr_q[DW*int'(idx_q) +: DW]  <= hr_nxt_s;
            rr_q[DW*int'(idx_q) +: DW]  <= rr_nxt_s;
            hrv_q[DW*int'(idx_q) +: DW] <= hrv_nxt_s;
            upd_q[idx_q]                <= 1'b1;
            inrng_q[idx_q]              <= hr_ok_s && rr_ok_s && hrv_ok_s;
          end
          if (idx_q == IW'(NUM_CH - 1)) begin
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + IW'(1'b1);
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign heart_rate_o  = hr_q;
  assign rr_interval_o = rr_q;
  assign hrv_value_o   = hrv_q;
  assign upd_valid_o   = upd_q;
  assign in_range_o    = inrng_q;
  assign tick_o        = tick_q;

endmodule
